// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared types for the rom fetch arbiter: FSM state, port id and width defaults.
// The optional last-word cache is enabled with `define ROM_LAST_WORD_CACHE_EN.
package rom_arb_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/rom_fetch_arbiter_rr.sv
// Two-input round-robin picker. On a tie the port that did not win last time
// is granted; rr_last resets to port 1 so port 0 wins the first tie.
module rr_arbiter2
  import rom_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_id_t   gnt_id
);

  port_id_t rr_last;

  always_comb begin
    gnt    = '0;
    gnt_id = PORT0;
    if (en) begin
      if (req == 2'b11) gnt_id = ~rr_last;
      else              gnt_id = req[1] ? PORT1 : PORT0;
      if (req != 2'b00) gnt[gnt_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rr_last <= PORT1;
    else if (|gnt) rr_last <= gnt_id;
  end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Serialises two requesters onto the single-transaction rom interface, with a
// watchdog on flash reads. `define ROM_LAST_WORD_CACHE_EN adds a one-entry hit cache.
module rom_fetch_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rom_start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ready,
  input  logic              rom_done,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  arb_state_e        state, state_nxt;
  port_id_t          grant_id, gnt_id;
  logic [1:0]        gnt;
  logic              arb_en, accept, timeout, cache_hit;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] hit_word;
  logic [CNT_W-1:0]  to_cnt;

  // Grants are masked while reset is held so every output reads 0 in reset.
  assign arb_en   = (state == IDLE) && rom_ready && reset_n;
  assign accept   = |gnt;
  assign acc_addr = (gnt_id == PORT1) ? req1_addr : req0_addr;
  assign timeout  = (state == WAIT) && !rom_done &&
                    (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en),
    .req     ({req1_valid, req0_valid}),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

`ifdef ROM_LAST_WORD_CACHE_EN
  logic              cache_v;
  logic [ADDR_W-1:0] cache_tag;
  logic [DATA_W-1:0] cache_word;

  // Only a completed rom read fills the entry; any abort invalidates it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cache_v    <= 1'b0;
      cache_tag  <= '0;
      cache_word <= '0;
    end else if (state == WAIT) begin
      if (rom_done) begin
        cache_v    <= 1'b1;
        cache_tag  <= rom_addr;
        cache_word <= rom_data;
      end else if (timeout) begin
        cache_v    <= 1'b0;
      end
    end
  end

  assign cache_hit = accept && cache_v && (cache_tag == acc_addr);
  assign hit_word  = cache_word;
`else
  assign cache_hit = 1'b0;
  assign hit_word  = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = cache_hit ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (rom_done || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    rom_start  = (state == ISSUE);
    rsp0_valid = (state == RESP) && (grant_id == PORT0);
    rsp1_valid = (state == RESP) && (grant_id == PORT1);
  end

  // rom_done wins over a watchdog expiry in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
      grant_id <= PORT0;
      to_cnt   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        rom_addr <= acc_addr;
        grant_id <= gnt_id;
      end
      if (cache_hit) begin
        rsp_data <= hit_word;
        rsp_err  <= 1'b0;
      end
      case (state)
        ISSUE: to_cnt <= '0;
        WAIT: begin
          to_cnt <= to_cnt + CNT_W'(1);
          if (rom_done) begin
            rsp_data <= rom_data;
            rsp_err  <= 1'b0;
          end else if (timeout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Self-checking bench for rom_fetch_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of arbitration, rom latency and cache.
module tb_rom_fetch_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic          req0_ready, rsp0_valid, req1_ready, rsp1_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err, rom_start;
  logic [AW-1:0] rom_addr;
  logic          rom_ready = 1'b0;
  logic          rom_done;
  logic [DW-1:0] rom_data;

  always #5 clk = ~clk;

  rom_fetch_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rom_start(rom_start), .rom_addr(rom_addr), .rom_ready(rom_ready),
    .rom_done(rom_done), .rom_data(rom_data)
  );

  typedef struct { int cyc; int port; logic [15:0] addr; bit both; } acc_t;
  typedef struct { int cyc; logic [15:0] addr; } st_t;
  typedef struct { int cyc; int port; logic [15:0] data; logic err; } rsp_t;

  acc_t acc_q[$];
  st_t  st_q[$];
  rsp_t rsp_q[$];
  int   lat_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int rom_lat = 4;
  bit rom_rand = 0;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    if (a == 16'h0005) return 16'hBEEF;
    if (a == 16'h1234) return 16'hCAFE;
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Flash model: answers rom_start after a chosen latency; a new start or reset drops a pending read.
  initial begin : rom_model
    bit pend;
    int left;
    logic [15:0] pa;
    pend = 0; left = 0; pa = '0;
    rom_done = 1'b0; rom_data = '0;
    forever begin
      @(negedge clk);
      rom_done = 1'b0;
      rom_data = 16'($urandom);
      if (!reset_n) pend = 0;
      else begin
        if (pend) begin
          left--;
          if (left == 0) begin rom_done = 1'b1; rom_data = rom_word(pa); pend = 0; end
        end
        if (rom_start) begin
          pend = 1; pa = rom_addr;
          left = rom_rand ? int'($urandom_range(1, 20)) : rom_lat;
          lat_q.push_back(left);
        end
      end
    end
  end

  initial begin : monitor
    acc_t a; st_t s; rsp_t r;
    forever begin
      @(negedge clk);
      cyc++;
      a.cyc = cyc; a.both = req0_valid && req1_valid;
      if (req0_ready) begin a.port = 0; a.addr = req0_addr; acc_q.push_back(a); end
      if (req1_ready) begin a.port = 1; a.addr = req1_addr; acc_q.push_back(a); end
      if (rom_start) begin s.cyc = cyc; s.addr = rom_addr; st_q.push_back(s); end
      r.cyc = cyc; r.data = rsp_data; r.err = rsp_err;
      if (rsp0_valid) begin r.port = 0; rsp_q.push_back(r); end
      if (rsp1_valid) begin r.port = 1; rsp_q.push_back(r); end
    end
  end

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear();
    acc_q.delete(); st_q.delete(); rsp_q.delete(); lat_q.delete();
  endtask

  task automatic send(input int p, input logic [15:0] a, output bit ok);
    ok = 0;
    if (p == 0) begin req0_valid = 1'b1; req0_addr = a; end
    else        begin req1_valid = 1'b1; req1_addr = a; end
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) ok = 1;
      @(posedge clk); #1;
    end
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < n && !ok; i++) begin
      tick();
      if (rsp_q.size() > 0) ok = 1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rom_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_addr = 16'h1111; req1_addr = 16'h2222;
    tick(3);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rom_start, rsp_err, rsp_data, rom_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rom_start, rsp_err, rsp_data, rom_addr});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    bit ok;
    clear(); rom_lat = 7; rom_ready = 1'b1;
    send(0, 16'h0005, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept: got no req0_ready want accept"); end
    wait_rsp(40, ok); tick(3);
    checks++;
    if (acc_q.size() != 1 || st_q.size() != 1 || rsp_q.size() != 1) begin
      errors++;
      $display("FAIL single_counts: got acc=%0d start=%0d rsp=%0d want 1/1/1", acc_q.size(), st_q.size(), rsp_q.size());
    end else begin
      checks++;
      if (st_q[0].addr !== 16'h0005 || st_q[0].cyc != acc_q[0].cyc + 1) begin
        errors++;
        $display("FAIL single_start: got addr=%h dcyc=%0d want 0005/1", st_q[0].addr, st_q[0].cyc - acc_q[0].cyc);
      end
      checks++;
      if (rsp_q[0].cyc != st_q[0].cyc + 8) begin
        errors++;
        $display("FAIL single_latency: got %0d want 8 cycles after rom_start", rsp_q[0].cyc - st_q[0].cyc);
      end
      checks++;
      if (rsp_q[0].port != 0 || rsp_q[0].data !== 16'hBEEF || rsp_q[0].err !== 1'b0) begin
        errors++;
        $display("FAIL single_rsp: got port=%0d data=%h err=%b want 0/BEEF/0", rsp_q[0].port, rsp_q[0].data, rsp_q[0].err);
      end
    end
  endtask

  task automatic test_round_robin();
    clear(); rom_lat = 2; rom_ready = 1'b1;
    reset_n = 1'b0;
    req0_addr = 16'h0010; req1_addr = 16'h0020; req0_valid = 1'b1; req1_valid = 1'b1;
    tick(2);
    reset_n = 1'b1;
    for (int i = 0; i < 100 && acc_q.size() < 4; i++) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(10);
    checks++;
    if (acc_q.size() < 4 || st_q.size() < 4) begin
      errors++;
      $display("FAIL rr_count: got acc=%0d start=%0d want >=4", acc_q.size(), st_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_q[i].port != i % 2 || st_q[i].addr !== ((i % 2 != 0) ? 16'h0020 : 16'h0010)) begin
          errors++;
          $display("FAIL rr_grant%0d: got port=%0d addr=%h want port=%0d", i, acc_q[i].port, st_q[i].addr, i % 2);
        end
      end
    end
  endtask

  task automatic test_rom_not_ready();
    bit ok;
    int c;
    clear(); rom_lat = 3; rom_ready = 1'b0;
    req0_addr = 16'h0042; req0_valid = 1'b1;
    tick(20);
    checks++;
    if (acc_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL notready_block: got acc=%0d start=%0d want 0/0", acc_q.size(), st_q.size());
    end
    c = cyc; rom_ready = 1'b1;
    for (int i = 0; i < 10 && acc_q.size() == 0; i++) tick();
    req0_valid = 1'b0;
    checks++;
    if (acc_q.size() != 1 || acc_q[0].cyc != c + 1) begin
      errors++;
      $display("FAIL notready_accept: got acc=%0d want accept in cycle ready rose", acc_q.size());
    end
    wait_rsp(20, ok); tick(2);
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0].data !== rom_word(16'h0042) || rsp_q[0].err !== 1'b0) begin
      errors++;
      $display("FAIL notready_rsp: got n=%0d want 1 rsp data=%h", rsp_q.size(), rom_word(16'h0042));
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear(); rom_lat = 20; rom_ready = 1'b1;
    send(1, 16'hFFFF, ok);
    wait_rsp(40, ok); tick(10);
    checks++;
    if (acc_q.size() != 1 || st_q.size() != 1 || rsp_q.size() != 1) begin
      errors++;
      $display("FAIL timeout_counts: got acc=%0d start=%0d rsp=%0d want 1/1/1", acc_q.size(), st_q.size(), rsp_q.size());
    end else begin
      checks++;
      if (rsp_q[0].port != 1 || rsp_q[0].err !== 1'b1 || rsp_q[0].data !== 16'h0000 || st_q[0].addr !== 16'hFFFF) begin
        errors++;
        $display("FAIL timeout_rsp: got port=%0d err=%b data=%h addr=%h want 1/1/0000/FFFF",
                 rsp_q[0].port, rsp_q[0].err, rsp_q[0].data, st_q[0].addr);
      end
      checks++;
      if (rsp_q[0].cyc != st_q[0].cyc + TO + 1) begin
        errors++;
        $display("FAIL timeout_latency: got %0d want %0d after rom_start", rsp_q[0].cyc - st_q[0].cyc, TO + 1);
      end
    end
    // rom_done landing on the final watchdog cycle still returns data
    clear(); rom_lat = TO;
    send(0, 16'h0000, ok);
    wait_rsp(40, ok); tick(2);
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0].err !== 1'b0 || rsp_q[0].data !== rom_word(16'h0000) ||
        rsp_q[0].cyc != acc_q[0].cyc + TO + 2) begin
      errors++;
      $display("FAIL timeout_edge: got n=%0d err=%b data=%h want err=0 data=%h", rsp_q.size(),
               rsp_q[0].err, rsp_q[0].data, rom_word(16'h0000));
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    clear(); rom_lat = 30; rom_ready = 1'b1;
    send(0, 16'h0100, ok);
    tick(4);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rom_start, rsp_err, rsp_data, rom_addr} !== '0) begin
      errors++;
      $display("FAIL midwait_reset_outputs: got %h want 0",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rom_start, rsp_err, rsp_data, rom_addr});
    end
    tick(2); reset_n = 1'b1; tick(40);
    checks++;
    if (rsp_q.size() != 0 || st_q.size() != 1) begin
      errors++;
      $display("FAIL midwait_discard: got rsp=%0d start=%0d want 0/1", rsp_q.size(), st_q.size());
    end
    clear(); rom_lat = 3;
    send(0, 16'h0033, ok);
    wait_rsp(20, ok); tick(2);
    checks++;
    if (rsp_q.size() != 1 || st_q.size() != 1 || rsp_q[0].data !== rom_word(16'h0033) ||
        rsp_q[0].err !== 1'b0 || rsp_q[0].cyc != acc_q[0].cyc + 5) begin
      errors++;
      $display("FAIL midwait_recover: got n=%0d data=%h want 1 rsp data=%h lat 5", rsp_q.size(),
               rsp_q[0].data, rom_word(16'h0033));
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int exp_starts, exp_lat;
`ifdef ROM_LAST_WORD_CACHE_EN
    exp_starts = 0; exp_lat = 1;
`else
    exp_starts = 1; exp_lat = 6;
`endif
    clear(); rom_lat = 4; rom_ready = 1'b1;
    send(0, 16'h1234, ok);
    wait_rsp(30, ok); tick(2);
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0].data !== 16'hCAFE || rsp_q[0].cyc != acc_q[0].cyc + 6) begin
      errors++;
      $display("FAIL b2b_first: got n=%0d data=%h want CAFE lat 6", rsp_q.size(), rsp_q[0].data);
    end
    clear();
    send(1, 16'h1234, ok);
    wait_rsp(30, ok); tick(2);
    checks++;
    if (rsp_q.size() != 1 || st_q.size() != exp_starts || rsp_q[0].port != 1 || rsp_q[0].data !== 16'hCAFE ||
        rsp_q[0].err !== 1'b0 || rsp_q[0].cyc - acc_q[0].cyc != exp_lat) begin
      errors++;
      $display("FAIL b2b_refetch: got starts=%0d lat=%0d data=%h want starts=%0d lat=%0d CAFE",
               st_q.size(), rsp_q[0].cyc - acc_q[0].cyc, rsp_q[0].data, exp_starts, exp_lat);
    end
    clear(); rom_lat = 20;
    send(0, 16'h5555, ok);
    wait_rsp(40, ok); tick(10);
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0].err !== 1'b1) begin
      errors++;
      $display("FAIL b2b_timeout: got n=%0d err=%b want 1 rsp err=1", rsp_q.size(), rsp_q[0].err);
    end
    clear(); rom_lat = 3;
    send(0, 16'h1234, ok);
    wait_rsp(30, ok); tick(2);
    checks++;
    if (rsp_q.size() != 1 || st_q.size() != 1 || rsp_q[0].data !== 16'hCAFE || rsp_q[0].cyc != acc_q[0].cyc + 5) begin
      errors++;
      $display("FAIL b2b_after_timeout: got starts=%0d data=%h want 1 start CAFE lat 5", st_q.size(), rsp_q[0].data);
    end
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h0005;
      3: return 16'h1234;
      4: return 16'h00AB;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    bit drop0 = 0, drop1 = 0, cv = 0, hit, ee;
    int last = 1, si = 0, l, exp_lat, n;
    logic [15:0] ca = '0, cd = '0, ed;
    reset_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; tick(2);
    reset_n = 1'b1; clear(); rom_rand = 1;
    for (int c = 0; c < 1500; c++) begin
      rom_ready = ($urandom_range(0, 7) != 0);
      if (drop0) begin req0_valid = 1'b0; drop0 = 0; end
      else if (!req0_valid) begin
        if ($urandom_range(0, 3) == 0) begin req0_valid = 1'b1; req0_addr = pick_addr(); end
      end else if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
      if (drop1) begin req1_valid = 1'b0; drop1 = 0; end
      else if (!req1_valid) begin
        if ($urandom_range(0, 3) == 0) begin req1_valid = 1'b1; req1_addr = pick_addr(); end
      end else if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
      @(negedge clk);
      if (req0_ready) drop0 = 1;
      if (req1_ready) drop1 = 1;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rom_ready = 1'b1;
    tick(40);
    rom_rand = 0;
    checks++;
    if (rsp_q.size() != acc_q.size() || acc_q.size() < 20) begin
      errors++;
      $display("FAIL rand_counts: got rsp=%0d acc=%0d want equal and >=20", rsp_q.size(), acc_q.size());
    end
    n = (rsp_q.size() < acc_q.size()) ? rsp_q.size() : acc_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (acc_q[i].both && acc_q[i].port == last) begin
        errors++;
        $display("FAIL rand_rr%0d: got port=%0d want %0d on tie", i, acc_q[i].port, 1 - last);
      end
      last = acc_q[i].port;
      hit = 0;
`ifdef ROM_LAST_WORD_CACHE_EN
      hit = cv && (ca == acc_q[i].addr);
`endif
      if (hit) begin
        exp_lat = 1; ed = cd; ee = 1'b0;
      end else begin
        if (si >= st_q.size()) begin
          checks++; errors++;
          $display("FAIL rand_missing_start%0d: got none want rom_start for %h", i, acc_q[i].addr);
          break;
        end
        l = lat_q[si];
        checks++;
        if (st_q[si].addr !== acc_q[i].addr || st_q[si].cyc != acc_q[i].cyc + 1) begin
          errors++;
          $display("FAIL rand_start%0d: got addr=%h want %h one cycle after accept", i, st_q[si].addr, acc_q[i].addr);
        end
        si++;
        if (l <= TO) begin
          ed = rom_word(acc_q[i].addr); ee = 1'b0; exp_lat = l + 2;
          cv = 1; ca = acc_q[i].addr; cd = ed;
        end else begin
          ed = '0; ee = 1'b1; exp_lat = TO + 2; cv = 0;
        end
      end
      checks++;
      if (rsp_q[i].port != acc_q[i].port || rsp_q[i].data !== ed || rsp_q[i].err !== ee ||
          rsp_q[i].cyc - acc_q[i].cyc != exp_lat) begin
        errors++;
        $display("FAIL rand_rsp%0d: got port=%0d data=%h err=%b lat=%0d want port=%0d data=%h err=%b lat=%0d",
                 i, rsp_q[i].port, rsp_q[i].data, rsp_q[i].err, rsp_q[i].cyc - acc_q[i].cyc,
                 acc_q[i].port, ed, ee, exp_lat);
      end
    end
    checks++;
    if (si != st_q.size()) begin
      errors++;
      $display("FAIL rand_extra_starts: got %0d rom_start want %0d", st_q.size(), si);
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_single();
    test_round_robin();
    test_rom_not_ready();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
